// File: rtl/debounce_pulse.sv
// debounce_pulse: synchronizes and debounces a bouncing push-button, emitting a clean level, stretched press/release pulses and a toggle
// Ports:
//   clk           system clock, rising-edge active
//   rst           asynchronous active-high reset
//   btn_in        raw button, asynchronous to clk, may bounce
//   btn_level     debounced button level
//   pulse_press   high for PULSE_CYCLES cycles per accepted press
//   pulse_release high for PULSE_CYCLES cycles per accepted release
//   toggle_q      inverts on every accepted press
//   busy          high while a candidate transition is being qualified
module debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 60000,
    parameter int CNT_W           = 16,
    parameter int PULSE_CYCLES    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic pulse_press,
    output logic pulse_release,
    output logic toggle_q,
    output logic busy
);
    typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       PW       = 8'(PULSE_CYCLES);
    state_t state_q, state_d;
    logic sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0] pcnt_q, pcnt_d, rcnt_q, rcnt_d;
    logic level_q, level_d, tog_q, tog_d, busy_q;
    logic last;
    assign last = cnt_q == CNT_LAST;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        tog_d   = tog_q;
        pcnt_d  = (pcnt_q != 8'd0) ? pcnt_q - 8'd1 : pcnt_q;
        rcnt_d  = (rcnt_q != 8'd0) ? rcnt_q - 8'd1 : rcnt_q;
        case (state_q)
            IDLE_LOW: if (sync2_q) begin
                state_d = WAIT_HIGH;
                cnt_d   = '0;
            end
            WAIT_HIGH: if (!sync2_q) begin
                state_d = IDLE_LOW;
            end else if (last) begin
                state_d = IDLE_HIGH;
                level_d = 1'b1;
                tog_d   = ~tog_q;
                pcnt_d  = PW;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            IDLE_HIGH: if (!sync2_q) begin
                state_d = WAIT_LOW;
                cnt_d   = '0;
            end
            WAIT_LOW: if (sync2_q) begin
                state_d = IDLE_HIGH;
            end else if (last) begin
                state_d = IDLE_LOW;
                level_d = 1'b0;
                rcnt_d  = PW;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        endcase
    end
    // busy is a flop loaded from the next state so it tracks the WAIT states cycle-exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            pcnt_q  <= 8'd0;
            rcnt_q  <= 8'd0;
            level_q <= 1'b0;
            tog_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            rcnt_q  <= rcnt_d;
            level_q <= level_d;
            tog_q   <= tog_d;
            busy_q  <= (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
        end
    end
    assign btn_level     = level_q;
    assign pulse_press   = pcnt_q != 8'd0;
    assign pulse_release = rcnt_q != 8'd0;
    assign toggle_q      = tog_q;
    assign busy          = busy_q;
endmodule
